// File: rtl/multibank_arbiter.sv
// Multi-bank memory scheduler: routes per-port read/write requests to banks by
// low address bits, with an independent round-robin arbiter per bank.
// Optional conflict counter output is enabled by defining MBA_CONFLICT_CNT_EN.
module multibank_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  localparam int BSW = $clog2(NUM_BANKS),
  localparam int BAW = ADDR_WIDTH - BSW
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  r_addr,
  input  logic [NUM_PORTS-1:0]             r_avalid,
  output logic [NUM_PORTS-1:0]             r_aready,
  output logic [NUM_PORTS-1:0]             r_dvalid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  r_data,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  w_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  w_data,
  input  logic [NUM_PORTS-1:0]             w_valid,
  output logic [NUM_PORTS-1:0]             w_ready,
  output logic [NUM_BANKS-1:0]             bank_en,
  output logic [NUM_BANKS-1:0]             bank_we,
  output logic [NUM_BANKS*BAW-1:0]         bank_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]  bank_wdata,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]  bank_rdata
`ifdef MBA_CONFLICT_CNT_EN
  ,
  output logic [31:0]                      conflict_cnt
`endif
);

  // Handshake: a transfer happens on a cycle where valid & ready are both 1.
  // Ready is combinational from valid and is never 1 while valid is 0; the
  // requester keeps valid/addr/data stable until it sees ready.

  localparam int NREQ = 2 * NUM_PORTS;
  localparam int RRW  = $clog2(NREQ);

  logic [RRW-1:0]        rr_q [NUM_BANKS];
  logic [RRW-1:0]        rr_d [NUM_BANKS];
  logic [NUM_PORTS-1:0]  rd_pend_q;
  logic [BSW-1:0]        rd_bank_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] r_hold_q [NUM_PORTS];

  // Requester index k: even = write of port k/2, odd = read of port k/2.
  always_comb begin : arb
    logic [NREQ-1:0] req;
    logic            found;
    int              idx;
    int              gidx;
    int              p;
    r_aready   = '0;
    w_ready    = '0;
    bank_en    = '0;
    bank_we    = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    req        = '0;
    found      = 1'b0;
    idx        = 0;
    gidx       = 0;
    p          = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rr_d[b] = rr_q[b];
      req     = '0;
      for (int q = 0; q < NUM_PORTS; q++) begin
        req[2*q]   = w_valid[q]  && (w_addr[q*ADDR_WIDTH +: BSW] == BSW'(b));
        req[2*q+1] = r_avalid[q] && (r_addr[q*ADDR_WIDTH +: BSW] == BSW'(b));
      end
      found = 1'b0;
      gidx  = 0;
      for (int i = 0; i < NREQ; i++) begin
        idx = int'(rr_q[b]) + i;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!found && req[idx]) begin
          found = 1'b1;
          gidx  = idx;
        end
      end
      if (found && rst_n) begin
        p          = gidx / 2;
        bank_en[b] = 1'b1;
        rr_d[b]    = (gidx == NREQ - 1) ? '0 : RRW'(gidx + 1);
        if (gidx % 2 == 0) begin
          bank_we[b]                             = 1'b1;
          w_ready[p]                             = 1'b1;
          bank_addr[b*BAW +: BAW]                = w_addr[p*ADDR_WIDTH + BSW +: BAW];
          bank_wdata[b*DATA_WIDTH +: DATA_WIDTH] = w_data[p*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          r_aready[p]             = 1'b1;
          bank_addr[b*BAW +: BAW] = r_addr[p*ADDR_WIDTH + BSW +: BAW];
        end
      end
    end
  end

  // Bank read data arrives one cycle after the grant; steer it straight out
  // while dvalid is high and hold the last value otherwise.
  always_comb begin
    r_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      r_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_pend_q[p]
        ? bank_rdata[int'(rd_bank_q[p])*DATA_WIDTH +: DATA_WIDTH]
        : r_hold_q[p];
    end
  end

  assign r_dvalid = rd_pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) rr_q[b] <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        rd_bank_q[p] <= '0;
        r_hold_q[p]  <= '0;
      end
    end else begin
      rd_pend_q <= r_avalid & r_aready;
      for (int b = 0; b < NUM_BANKS; b++) rr_q[b] <= rr_d[b];
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (r_avalid[p] && r_aready[p]) rd_bank_q[p] <= r_addr[p*ADDR_WIDTH +: BSW];
        r_hold_q[p] <= r_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef MBA_CONFLICT_CNT_EN
  logic [31:0] cnt_q;
  logic        stall;

  // One increment per cycle no matter how many requesters are stalled.
  assign stall        = (|(r_avalid & ~r_aready)) || (|(w_valid & ~w_ready));
  assign conflict_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multibank_arbiter.sv
// Directed scoreboard bench for multibank_arbiter with a 1-cycle bank RAM model.
// Builds with or without MBA_CONFLICT_CNT_EN.
module tb_multibank_arbiter;

  localparam int NP  = 4;
  localparam int NB  = 4;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int BAW = 6;

  logic              clk;
  logic              rst_n;
  logic [NP*AW-1:0]  r_addr;
  logic [NP-1:0]     r_avalid;
  logic [NP-1:0]     r_aready;
  logic [NP-1:0]     r_dvalid;
  logic [NP*DW-1:0]  r_data;
  logic [NP*AW-1:0]  w_addr;
  logic [NP*DW-1:0]  w_data;
  logic [NP-1:0]     w_valid;
  logic [NP-1:0]     w_ready;
  logic [NB-1:0]     bank_en;
  logic [NB-1:0]     bank_we;
  logic [NB*BAW-1:0] bank_addr;
  logic [NB*DW-1:0]  bank_wdata;
  logic [NB*DW-1:0]  bank_rdata;
`ifdef MBA_CONFLICT_CNT_EN
  logic [31:0]       conflict_cnt;
`endif

  multibank_arbiter #(
    .NUM_PORTS(NP), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .r_addr(r_addr), .r_avalid(r_avalid), .r_aready(r_aready),
    .r_dvalid(r_dvalid), .r_data(r_data),
    .w_addr(w_addr), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
`ifdef MBA_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bank RAM model ----------------
  bit          wr_vld [NB][64];
  logic [31:0] mem    [NB][64];
  logic [31:0] rdq    [NB];

  function automatic logic [31:0] init_word(int b, int a);
    return 32'h1000_0000 + 32'(b * 256) + 32'(a);
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bank_en[b]) begin
        if (bank_we[b]) begin
          mem[b][bank_addr[b*BAW +: BAW]]    <= bank_wdata[b*DW +: DW];
          wr_vld[b][bank_addr[b*BAW +: BAW]] <= 1'b1;
        end else begin
          rdq[b] <= wr_vld[b][bank_addr[b*BAW +: BAW]] ? mem[b][bank_addr[b*BAW +: BAW]]
                                                        : init_word(b, int'(bank_addr[b*BAW +: BAW]));
        end
      end
    end
  end

  assign bank_rdata = {rdq[3], rdq[2], rdq[1], rdq[0]};

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_mis = 0;
  logic [39:0] gnt_exp_q[$];  // {w_ready, r_aready, bank_en, bank_we, bank_addr}
  logic [33:0] rd_exp_q[$];   // {port, data}

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_mis++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  function automatic logic [39:0] grec(logic [3:0] wr, logic [3:0] ra, logic [3:0] en,
                                       logic [3:0] we, logic [23:0] ad);
    return {wr, ra, en, we, ad};
  endfunction

  int rwait [NP];
  int wwait [NP];

  // Monitor: pops expectations whenever the DUT presents a grant or read data.
  always @(negedge clk) begin
    logic [33:0] e;
    logic [39:0] g;
    for (int p = 0; p < NP; p++) begin
      if (r_dvalid[p]) begin
        if (rd_exp_q.size() == 0) flag($sformatf("unexpected r_dvalid port %0d", p));
        else begin
          e = rd_exp_q.pop_front();
          check("rdata", {94'd0, 2'(p), r_data[p*DW +: DW]}, {94'd0, e});
        end
      end
    end
    if (rst_n) begin
      if (|{w_ready, r_aready, bank_en}) begin
        if (gnt_exp_q.size() == 0) flag("unexpected grant");
        else begin
          g = gnt_exp_q.pop_front();
          check("grant", {88'd0, w_ready, r_aready, bank_en, bank_we, bank_addr}, {88'd0, g});
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (r_avalid[p] && r_aready[p]) begin
          n_cmp++;
          if (rwait[p] > 2*NP-1) begin
            n_mis++;
            $display("FAIL r_wait port %0d: waited %0d cycles, limit %0d", p, rwait[p], 2*NP-1);
          end
          rwait[p] = 0;
        end else if (r_avalid[p]) rwait[p]++;
        else rwait[p] = 0;
        if (w_valid[p] && w_ready[p]) begin
          n_cmp++;
          if (wwait[p] > 2*NP-1) begin
            n_mis++;
            $display("FAIL w_wait port %0d: waited %0d cycles, limit %0d", p, wwait[p], 2*NP-1);
          end
          wwait[p] = 0;
        end else if (w_valid[p]) wwait[p]++;
        else wwait[p] = 0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        rwait[p] = 0;
        wwait[p] = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_read(input int p, input logic [7:0] a, input int n);
    bit got;
    @(posedge clk); #1;
    r_addr[p*AW +: AW] = a;
    r_avalid[p]        = 1'b1;
    for (int k = 0; k < n; k++) begin
      got = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
        @(negedge clk);
        if (r_aready[p]) got = 1'b1;
      end
      if (!got) flag($sformatf("read timeout port %0d", p));
      @(posedge clk); #1;
    end
    r_avalid[p] = 1'b0;
  endtask

  task automatic do_write(input int p, input logic [7:0] a, input logic [31:0] d);
    bit got;
    @(posedge clk); #1;
    w_addr[p*AW +: AW] = a;
    w_data[p*DW +: DW] = d;
    w_valid[p]         = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (w_ready[p]) got = 1'b1;
    end
    if (!got) flag($sformatf("write timeout port %0d", p));
    @(posedge clk); #1;
    w_valid[p] = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    r_avalid = 4'hF;
    w_valid  = 4'hF;
    #1;
    check({tag, "_r_aready"}, {124'd0, r_aready}, 128'd0);
    check({tag, "_w_ready"},  {124'd0, w_ready},  128'd0);
    check({tag, "_bank_en"},  {124'd0, bank_en},  128'd0);
    check({tag, "_bank_addr"}, {104'd0, bank_addr}, 128'd0);
    check({tag, "_r_dvalid"}, {124'd0, r_dvalid}, 128'd0);
    check({tag, "_r_data"},   r_data, 128'd0);
    r_avalid = '0;
    w_valid  = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    r_addr   = '0;
    r_avalid = '0;
    w_addr   = '0;
    w_data   = '0;
    w_valid  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst0");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: write 0x05 then read 0x05 from another port
    apply_reset();
    gnt_exp_q.push_back(grec(4'b0001, 4'b0000, 4'b0010, 4'b0010, 24'h000040));
    gnt_exp_q.push_back(grec(4'b0000, 4'b0010, 4'b0010, 4'b0000, 24'h000040));
    rd_exp_q.push_back({2'd1, 32'hDEAD_BEEF});
    fork
      do_write(0, 8'h05, 32'hDEAD_BEEF);
      begin @(posedge clk); do_read(1, 8'h05, 1); end
    join
    repeat (3) @(posedge clk);

    // 2: four ports read four different banks at once
    apply_reset();
    gnt_exp_q.push_back(grec(4'b0000, 4'b1111, 4'b1111, 4'b0000, 24'h0));
    rd_exp_q.push_back({2'd0, 32'h1000_0000});
    rd_exp_q.push_back({2'd1, 32'h1000_0100});
    rd_exp_q.push_back({2'd2, 32'h1000_0200});
    rd_exp_q.push_back({2'd3, 32'h1000_0300});
    fork
      do_read(0, 8'h00, 1);
      do_read(1, 8'h01, 1);
      do_read(2, 8'h02, 1);
      do_read(3, 8'h03, 1);
    join
    repeat (3) @(posedge clk);

    // 3: all ports contend on bank 2 -> strict rotation r0..r3
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < NP; p++) begin
        gnt_exp_q.push_back(grec(4'b0000, 4'(1 << p), 4'b0100, 4'b0000, 24'h0));
        rd_exp_q.push_back({2'(p), 32'h1000_0200});
      end
    end
    fork
      do_read(0, 8'h02, 3);
      do_read(1, 8'h02, 3);
      do_read(2, 8'h02, 3);
      do_read(3, 8'h02, 3);
`ifdef MBA_CONFLICT_CNT_EN
      begin
        for (int t = 0; t < 50; t++) begin
          @(negedge clk);
          if (|r_aready) break;
        end
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("conflict_cnt", {96'd0, conflict_cnt}, 128'd8);
      end
`endif
    join
    repeat (3) @(posedge clk);

    // 4: same-cycle write and read to one address from port 0
    apply_reset();
    gnt_exp_q.push_back(grec(4'b0001, 4'b0000, 4'b0001, 4'b0001, 24'h000002));
    gnt_exp_q.push_back(grec(4'b0000, 4'b0001, 4'b0001, 4'b0000, 24'h000002));
    rd_exp_q.push_back({2'd0, 32'h0000_0011});
    fork
      do_write(0, 8'h08, 32'h0000_0011);
      do_read(0, 8'h08, 1);
    join
    repeat (3) @(posedge clk);

    // 5: read accepted right before reset must not return data
    apply_reset();
    gnt_exp_q.push_back(grec(4'b0000, 4'b1000, 4'b1000, 4'b0000, 24'h040000));
    @(posedge clk); #1;
    r_addr[3*AW +: AW] = 8'h07;
    r_avalid[3]        = 1'b1;
    @(negedge clk);
    @(posedge clk);
    rst_n    = 1'b0;
    r_avalid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst5_r_dvalid", {124'd0, r_dvalid}, 128'd0);
    end
    check_reset_outputs("rst5");
    @(posedge clk); #1;
    rst_n = 1'b1;
    gnt_exp_q.push_back(grec(4'b0000, 4'b0001, 4'b0001, 4'b0000, 24'h0));
    gnt_exp_q.push_back(grec(4'b0000, 4'b0010, 4'b0001, 4'b0000, 24'h0));
    gnt_exp_q.push_back(grec(4'b0100, 4'b0000, 4'b0001, 4'b0001, 24'h000003));
    gnt_exp_q.push_back(grec(4'b0000, 4'b0100, 4'b0001, 4'b0000, 24'h0));
    gnt_exp_q.push_back(grec(4'b0000, 4'b1000, 4'b0001, 4'b0000, 24'h0));
    for (int p = 0; p < NP; p++) rd_exp_q.push_back({2'(p), 32'h1000_0000});
    fork
      do_read(0, 8'h00, 1);
      do_read(1, 8'h00, 1);
      do_write(2, 8'h0C, 32'hCAFE_0002);
      do_read(2, 8'h00, 1);
      do_read(3, 8'h00, 1);
    join
    repeat (4) @(posedge clk);

    check("gnt_queue_left", 128'(gnt_exp_q.size()), 128'd0);
    check("rd_queue_left",  128'(rd_exp_q.size()),  128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
